// File: rtl/hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO control unit.
// Holds the FSM state encoding, the default multiply/divide latencies and
// a helper that sizes the latency counter.
package hilo_ctrl_pkg;

  localparam int unsigned MULT_LAT_DEF = 32;
  localparam int unsigned DIV_LAT_DEF  = 33;

  typedef logic [1:0] hilo_state_t;

  localparam hilo_state_t StIdle     = 2'd0;
  localparam hilo_state_t StMultWait = 2'd1;
  localparam hilo_state_t StDivWait  = 2'd2;

  // Bits needed to hold max(a, b) - 1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    if (m <= 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/hilo_lat_counter.sv
// Loadable down-counter used to time multiply/divide completion.
// Ports:
//   clk, reset       - clock, asynchronous active-low reset
//   load, load_val   - load the counter (highest priority)
//   clr              - force the counter to zero
//   dec              - decrement by one, saturating at zero
//   zero             - counter currently equals zero
module hilo_lat_counter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (clr) begin
      cnt_d = '0;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO architectural register control for a multi-cycle multiplier and
// divider. Captures the unit result after a fixed latency, supports direct
// MTHI/MTLO writes while idle and reports aborted divide-by-zero.
// Ports:
//   clk, reset             - clock, asynchronous active-low reset
//   multCtrl, divCtrl      - one-cycle start pulses (divide wins if both)
//   multHi/multLo          - multiplier result halves
//   divHi/divLo, divZero   - divider remainder/quotient and zero-divisor flag
//   mthiWr, mtloWr, wrData - direct HI/LO writes
//   hi, lo                 - architectural registers
//   busy                   - an operation is in flight
//   divZeroExc             - one-cycle pulse after an aborted divide
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int unsigned N_BITS   = 32,
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              multCtrl,
  input  logic              divCtrl,
  input  logic [N_BITS-1:0] multHi,
  input  logic [N_BITS-1:0] multLo,
  input  logic [N_BITS-1:0] divHi,
  input  logic [N_BITS-1:0] divLo,
  input  logic              divZero,
  input  logic              mthiWr,
  input  logic              mtloWr,
  input  logic [N_BITS-1:0] wrData,
  output logic [N_BITS-1:0] hi,
  output logic [N_BITS-1:0] lo,
  output logic              busy,
  output logic              divZeroExc
);

  localparam int unsigned CntW = cnt_width(MULT_LAT, DIV_LAT);
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_LAT - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_LAT - 1);

  hilo_state_t       state_q, state_d;
  logic [N_BITS-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              exc_q, exc_d;

  logic            cnt_load, cnt_clr, cnt_dec, cnt_zero;
  logic [CntW-1:0] cnt_load_val;

  hilo_lat_counter #(
    .WIDTH(CntW)
  ) u_lat_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .clr     (cnt_clr),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    exc_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_clr      = 1'b0;
    cnt_dec      = 1'b0;
    case (state_q)
      StIdle: begin
        if (divCtrl) begin
          state_d      = StDivWait;
          cnt_load     = 1'b1;
          cnt_load_val = DivLoad;
        end else if (multCtrl) begin
          state_d      = StMultWait;
          cnt_load     = 1'b1;
          cnt_load_val = MultLoad;
        end else begin
          // Direct writes only when no start is accepted this cycle.
          if (mthiWr) hi_d = wrData;
          if (mtloWr) lo_d = wrData;
        end
      end
      StMultWait: begin
        if (cnt_zero) begin
          hi_d    = multHi;
          lo_d    = multLo;
          state_d = StIdle;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StDivWait: begin
        // Divide-by-zero aborts even on the would-be commit edge.
        if (divZero) begin
          exc_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = StIdle;
        end else if (cnt_zero) begin
          hi_d    = divHi;
          lo_d    = divLo;
          state_d = StIdle;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      exc_q   <= exc_d;
    end
  end

  assign hi         = hi_q;
  assign lo         = lo_q;
  assign busy       = (state_q != StIdle);
  assign divZeroExc = exc_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed self-checking bench for hilo_ctrl with a result scoreboard.
module tb_hilo_ctrl;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        multCtrl, divCtrl, divZero, mthiWr, mtloWr;
  logic [31:0] multHi, multLo, divHi, divLo, wrData;
  logic [31:0] hi, lo;
  logic        busy, divZeroExc;

  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  logic [31:0] mh, ml;  // bench model of hi/lo

  hilo_ctrl #(
    .N_BITS  (32),
    .MULT_LAT(32),
    .DIV_LAT (33)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .multCtrl  (multCtrl),
    .divCtrl   (divCtrl),
    .multHi    (multHi),
    .multLo    (multLo),
    .divHi     (divHi),
    .divLo     (divLo),
    .divZero   (divZero),
    .mthiWr    (mthiWr),
    .mtloWr    (mtloWr),
    .wrData    (wrData),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .divZeroExc(divZeroExc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=empty scoreboard expected=pending entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_hi"}, hi, e.hi);
      check({tag, "_lo"}, lo, e.lo);
    end
  endtask

  // Start an operation, check the result is not visible one edge early and
  // lands exactly at E0+lat.
  task automatic op(input logic is_div, input logic [31:0] h, input logic [31:0] l,
                    input int lat, input string tag);
    if (is_div) begin
      divHi = h; divLo = l; divCtrl = 1'b1;
    end else begin
      multHi = h; multLo = l; multCtrl = 1'b1;
    end
    sb.push_back('{hi: h, lo: l});
    step();
    divCtrl = 1'b0; multCtrl = 1'b0;
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    repeat (lat - 1) step();
    check({tag, "_busy_early"}, 32'(busy), 32'd1);
    check({tag, "_hi_early"}, hi, mh);
    check({tag, "_lo_early"}, lo, ml);
    step();
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    pop_check(tag);
    mh = h; ml = l;
  endtask

  initial begin
    multCtrl = 0; divCtrl = 0; divZero = 0; mthiWr = 0; mtloWr = 0;
    multHi = 0; multLo = 0; divHi = 0; divLo = 0; wrData = 0;
    mh = 32'h0; ml = 32'h0;

    // Reset state
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) step();
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_exc", 32'(divZeroExc), 32'd0);
    reset = 1'b1;

    // -24/6 divide, then 190/13
    op(1'b1, 32'h0, 32'hFFFF_FFFC, 33, "div_neg");
    op(1'b1, 32'd8, 32'd14, 33, "div_190_13");

    // MTHI then multiply
    mthiWr = 1'b1; wrData = 32'hA5A5_A5A5;
    step();
    mthiWr = 1'b0;
    mh = 32'hA5A5_A5A5;
    check("mthi_hi", hi, mh);
    check("mthi_lo", lo, ml);
    op(1'b0, 32'd1, 32'd2, 32, "mult");

    // Both direct writes together
    mthiWr = 1'b1; mtloWr = 1'b1; wrData = 32'h1234_5678;
    step();
    mthiWr = 1'b0; mtloWr = 1'b0;
    check("mtboth_hi", hi, 32'h1234_5678);
    check("mtboth_lo", lo, 32'h1234_5678);
    // Write in the same cycle as a start is dropped
    multHi = 32'd1; multLo = 32'd2; multCtrl = 1'b1;
    mthiWr = 1'b1; wrData = 32'hDEAD_BEEF;
    step();
    multCtrl = 1'b0; mthiWr = 1'b0;
    check("wr_with_start_hi", hi, 32'h1234_5678);
    repeat (32) step();
    check("wr_with_start_commit_hi", hi, 32'd1);
    check("wr_with_start_commit_lo", lo, 32'd2);
    mh = 32'd1; ml = 32'd2;

    // Divide-by-zero abort two cycles after start
    divHi = 32'h55; divLo = 32'h66; divCtrl = 1'b1;
    sb.push_back('{hi: mh, lo: ml});
    step();
    divCtrl = 1'b0;
    step();
    check("dz_busy_pre", 32'(busy), 32'd1);
    check("dz_exc_pre", 32'(divZeroExc), 32'd0);
    divZero = 1'b1;
    step();
    divZero = 1'b0;
    check("dz_exc", 32'(divZeroExc), 32'd1);
    check("dz_busy", 32'(busy), 32'd0);
    pop_check("dz_keep");
    step();
    check("dz_exc_once", 32'(divZeroExc), 32'd0);
    // divZero outside DIV_WAIT is ignored
    divZero = 1'b1;
    step();
    divZero = 1'b0;
    check("dz_idle_exc", 32'(divZeroExc), 32'd0);

    // Simultaneous starts, late MTLO and second divide ignored
    divHi = 32'h11; divLo = 32'h22; multHi = 32'h33; multLo = 32'h44;
    divCtrl = 1'b1; multCtrl = 1'b1;
    sb.push_back('{hi: 32'h11, lo: 32'h22});
    step();
    divCtrl = 1'b0; multCtrl = 1'b0;
    repeat (9) step();
    mtloWr = 1'b1; wrData = 32'hCAFE_F00D; divCtrl = 1'b1;
    step();
    mtloWr = 1'b0; divCtrl = 1'b0;
    check("both_busy_mid", 32'(busy), 32'd1);
    check("both_lo_mid", lo, ml);
    repeat (22) step();
    check("both_busy_early", 32'(busy), 32'd1);
    check("both_hi_early", hi, mh);
    step();
    check("both_busy_done", 32'(busy), 32'd0);
    pop_check("both_div");
    mh = 32'h11; ml = 32'h22;
    step();
    check("both_no_restart", 32'(busy), 32'd0);

    // Reset mid-divide
    divHi = 32'h77; divLo = 32'h88; divCtrl = 1'b1;
    step();
    divCtrl = 1'b0;
    repeat (15) step();
    reset = 1'b0;
    #1;
    check("mid_rst_hi", hi, 32'h0);
    check("mid_rst_lo", lo, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    mh = 32'h0; ml = 32'h0;
    repeat (2) step();
    reset = 1'b1;
    repeat (20) step();
    check("no_commit_hi", hi, 32'h0);
    check("no_commit_lo", lo, 32'h0);
    check("no_commit_busy", 32'(busy), 32'd0);

    // First start right after reset release is accepted
    reset = 1'b0;
    step();
    reset = 1'b1;
    op(1'b0, 32'h7, 32'h8, 32, "post_rst_mult");

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameter N_BITS, default 32: datapath width of HI, LO and all data ports.
REQ-002 Parameter MULT_LAT, default 32: clock edges from an accepted multiply start to commit.
REQ-003 Parameter DIV_LAT, default 33: clock edges from an accepted divide start to commit.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 multCtrl  in  1  one-cycle multiply start pulse, issued alongside the multiplier's own start.
REQ-007 divCtrl  in  1  one-cycle divide start pulse, issued alongside the divider's divCtrl.
REQ-008 multHi, multLo  in  N_BITS each  multiplier result halves.
REQ-009 divHi, divLo  in  N_BITS each  divider remainder (divHi) and quotient (divLo).
REQ-010 divZero  in  1  divider's divide-by-zero flag.
REQ-011 mthiWr, mtloWr  in  1 each  direct HI / LO write enables (MTHI/MTLO).
REQ-012 wrData  in  N_BITS  data for mthiWr/mtloWr.
REQ-013 hi, lo  out  N_BITS each  architectural HI/LO registers, always visible (MFHI/MFLO source).
REQ-014 busy  out  1  operation in flight; control unit stalls MFHI/MFLO/MTHI/MTLO and new starts while high.
REQ-015 divZeroExc  out  1  one-cycle pulse reporting an aborted divide-by-zero.

Function
REQ-016 States: IDLE, MULT_WAIT, DIV_WAIT; busy is 1 exactly in MULT_WAIT and DIV_WAIT.
REQ-017 IDLE + divCtrl at edge E0 -> DIV_WAIT; counter loaded with DIV_LAT-1.
REQ-018 IDLE + multCtrl (divCtrl low) at E0 -> MULT_WAIT; counter loaded with MULT_LAT-1.
REQ-019 divCtrl and multCtrl both high in IDLE -> divide accepted, multiply ignored.
REQ-020 Counter decrements once per edge in a WAIT state; never wraps below 0.
REQ-021 Edge with counter == 0 in MULT_WAIT: hi <= multHi, lo <= multLo, state -> IDLE, so commit occurs at edge E0+MULT_LAT.
REQ-022 Edge with counter == 0 in DIV_WAIT: hi <= divHi, lo <= divLo, state -> IDLE, so commit occurs at edge E0+DIV_LAT.
REQ-023 divZero high at any edge in DIV_WAIT -> abort: hi/lo unchanged, divZeroExc = 1 for the following cycle only, state -> IDLE.
REQ-024 divZero is ignored outside DIV_WAIT; divZeroExc is otherwise 0.
REQ-025 multCtrl/divCtrl while busy are ignored; the in-flight operation is unaffected.
REQ-026 In IDLE with no start: mthiWr -> hi <= wrData, mtloWr -> lo <= wrData; both high writes both.
REQ-027 mthiWr/mtloWr while busy, or in the same cycle as an accepted start, are dropped.
REQ-028 hi/lo hold their value in every cycle without a commit or direct write.

Reset
REQ-029 reset low asynchronously forces state IDLE, counter 0, hi 0, lo 0, busy 0, divZeroExc 0.
REQ-030 Reset mid-operation discards the in-flight result; after release, no commit occurs for it.
REQ-031 First start is accepted at the first rising edge after reset deassertion.

Structure
REQ-032 A shared package holds the state enum and the MULT_LAT/DIV_LAT defaults, for reuse by the control unit and benches.
REQ-033 One sub-module, hilo_lat_counter: loadable down-counter with a zero flag, sized to hold max(MULT_LAT, DIV_LAT)-1.

Verification
REQ-034 Release reset, divCtrl pulse with divHi=0, divLo=0xFFFFFFFC (-24/6) -> busy for 33 cycles, then hi=0, lo=0xFFFFFFFC, busy=0.
REQ-035 Divide 190/13 (divHi=8, divLo=14) -> at E0+33, hi=8 and lo=14; values unchanged at E0+32.
REQ-036 divCtrl with divZero raised 2 cycles later -> divZeroExc pulses once, hi/lo keep prior values, busy drops next cycle.
REQ-037 In IDLE, mthiWr with wrData=0xA5A5A5A5, then multCtrl with multHi=1, multLo=2 -> hi=0xA5A5A5A5 until E0+32, then hi=1, lo=2.
REQ-038 Simultaneous divCtrl+multCtrl, then mtloWr and a second divCtrl at E0+10 -> divide-path result only, committed at E0+33; the write and the second start are both ignored.
REQ-039 Reset asserted at E0+15 of a divide -> hi=lo=0 and busy=0 immediately; no commit at E0+33.
